uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command controller at the far end of the UART link. It consumes received bytes from the UART receiver and decodes register write/read frames. It drives a register-file port and pushes read responses into the TX FIFO that feeds the UART transmitter. The block sits between the UART pair and the system register file.

Parameters:
DATA_WIDTH, 8, byte width of the UART, register-file and FIFO data paths
ADDR_WIDTH, 4, register-file address width
WR_CMD, 8'hAA, opcode for a register write frame
RD_CMD, 8'hBB, opcode for a register read frame
RD_TIMEOUT, 15, maximum cycles to wait for RF_RdData_VLD

Ports:
CLK  in  1  single clock for the whole block
RST  in  1  synchronous, active-high reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid
RX_ERR  in  1  parity or framing error on the current byte; qualified by RX_D_VLD
RF_Address  out  ADDR_WIDTH  register-file address
RF_WrEn  out  1  register-file write strobe
RF_RdEn  out  1  register-file read strobe
RF_WrData  out  DATA_WIDTH  register-file write data
RF_RdData  in  DATA_WIDTH  register-file read data
RF_RdData_VLD  in  1  read data valid strobe
TX_P_DATA  out  DATA_WIDTH  byte pushed to the TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe
FIFO_FULL  in  1  TX FIFO full
Busy  out  1  frame in progress
CMD_ERR  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset (RST high at a CLK edge): state IDLE, timeout counter 0.
  - All outputs 0: RF_Address, RF_WrEn, RF_RdEn, RF_WrData, TX_P_DATA, TX_D_VLD, Busy, CMD_ERR.
  - Reset mid-frame discards the partial frame; no strobes are issued.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_PUSH.
- Busy = (state != IDLE), combinational.
- IDLE, on RX_D_VLD:
  - byte == WR_CMD -> WR_ADDR.
  - byte == RD_CMD -> RD_ADDR.
  - any other byte is silently ignored; no CMD_ERR.
- WR_ADDR, on RX_D_VLD: latch byte[ADDR_WIDTH-1:0] into the address register -> WR_DATA.
  - If any bit above ADDR_WIDTH-1 is set: pulse CMD_ERR -> IDLE.
- WR_DATA, on RX_D_VLD at cycle N:
  - RF_WrData = byte and RF_WrEn = 1 at cycle N+1, for exactly one cycle.
  - RF_Address holds the latched address -> IDLE.
- RD_ADDR, on RX_D_VLD at cycle N:
  - Same address check as WR_ADDR.
  - RF_RdEn = 1 at N+1, for one cycle -> RD_WAIT; timeout counter cleared.
- RD_WAIT:
  - On RF_RdData_VLD at cycle M: latch RF_RdData into TX_P_DATA -> TX_PUSH at M+1.
  - Counter increments each cycle; on reaching RD_TIMEOUT without RF_RdData_VLD: pulse CMD_ERR -> IDLE.
  - RF_RdData_VLD in the same cycle the counter reaches RD_TIMEOUT: the data wins.
- TX_PUSH:
  - TX_D_VLD = (state == TX_PUSH) && !FIFO_FULL, combinational.
  - Leaves to IDLE in the cycle TX_D_VLD is 1.
  - While FIFO_FULL stays high: hold with no timeout; TX_P_DATA stable.
- RX_D_VLD with RX_ERR = 1, any state except RD_WAIT/TX_PUSH: byte discarded.
  - Pulse CMD_ERR if the state was not IDLE; -> IDLE.
  - In IDLE the errored byte is dropped silently.
- RX_D_VLD during RD_WAIT or TX_PUSH: byte dropped, CMD_ERR pulsed, state unaffected.
- CMD_ERR is a registered pulse, asserted the cycle after the abort condition; never longer than one cycle per event.
- RF_WrEn and RF_RdEn are never asserted together; RF_Address is unchanged while either is high.
- Multiple back-to-back frames need no idle gap between bytes: the next opcode is accepted in the cycle after returning to IDLE.

Test Plan:
- Write: bytes AA, 03, 5C with RX_D_VLD one cycle each -> RF_WrEn pulse one cycle after the 5C strobe, RF_Address=3, RF_WrData=5C; Busy low afterwards.
- Read: BB, 07; RF model returns 9E two cycles after RF_RdEn -> RF_RdEn one cycle after the 07 strobe; TX_D_VLD one cycle after RF_RdData_VLD with TX_P_DATA=9E.
- Backpressure: read as above with FIFO_FULL high for 10 cycles -> TX_D_VLD stays 0, TX_P_DATA=9E holds; single TX_D_VLD in the first cycle FIFO_FULL is low.
- Errors:
  - AA, 13 -> CMD_ERR pulse, no RF_WrEn.
  - AA, 02, then byte with RX_ERR=1 -> CMD_ERR, no write.
  - Stray byte 55 in IDLE -> ignored, no CMD_ERR.
- Timeout: BB, 01 with no RF_RdData_VLD -> CMD_ERR pulse RD_TIMEOUT cycles after entering RD_WAIT; next AA, 01, 22 completes normally.
- Reset mid-frame: RST high after AA, 04 -> all outputs 0; following 22 byte ignored (IDLE), no RF_WrEn.

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between the UART command controller and its neighbours:
// the UART receiver, the register file and the TX FIFO.
interface uart_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    // All *_VLD / *En signals are single-cycle strobes with no acknowledge.
    // The only flow control is FIFO_FULL: a TX_D_VLD strobe is issued only
    // in a cycle where FIFO_FULL is low, and that strobe counts as the push.
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  RX_ERR;
    logic [ADDR_WIDTH-1:0] RF_Address;
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [DATA_WIDTH-1:0] RF_WrData;
    logic [DATA_WIDTH-1:0] RF_RdData;
    logic                  RF_RdData_VLD;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  FIFO_FULL;
    logic                  Busy;
    logic                  CMD_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RX_ERR, RF_RdData, RF_RdData_VLD, FIFO_FULL,
        output RF_Address, RF_WrEn, RF_RdEn, RF_WrData, TX_P_DATA, TX_D_VLD,
               Busy, CMD_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RX_ERR, RF_RdData, RF_RdData_VLD, FIFO_FULL,
        input  RF_Address, RF_WrEn, RF_RdEn, RF_WrData, TX_P_DATA, TX_D_VLD,
               Busy, CMD_ERR
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Decodes UART write/read frames into register-file accesses and pushes
// read responses into the TX FIFO.
module uart_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int                    RD_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST,
    uart_cmd_ctrl_if.master  bus,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_PUSH = 3'd5
    } state_t;

    localparam int               CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_n;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic                  wr_en_q, wr_en_n;
    logic                  rd_en_q, rd_en_n;
    logic                  err_q, err_n;
    logic                  addr_ok;
    logic                  rx_ok;

    // An address byte is only legal if it fits the register-file address space.
    assign addr_ok = ((bus.RX_P_DATA >> ADDR_WIDTH) == '0);
    assign rx_ok   = bus.RX_D_VLD && !bus.RX_ERR;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            addr_q    <= addr_n;
            wr_data_q <= wr_data_n;
            tx_data_q <= tx_data_n;
            cnt_q     <= cnt_n;
            wr_en_q   <= wr_en_n;
            rd_en_q   <= rd_en_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        addr_n    = addr_q;
        wr_data_n = wr_data_q;
        tx_data_n = tx_data_q;
        cnt_n     = cnt_q;
        wr_en_n   = 1'b0;
        rd_en_n   = 1'b0;
        err_n     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_ok) begin
                    if (bus.RX_P_DATA == WR_CMD) begin
                        state_n = WR_ADDR;
                    end else if (bus.RX_P_DATA == RD_CMD) begin
                        state_n = RD_ADDR;
                    end
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_ERR || !addr_ok) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        addr_n = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        if (state_q == WR_ADDR) begin
                            state_n = WR_DATA;
                        end else begin
                            rd_en_n = 1'b1;
                            cnt_n   = '0;
                            state_n = RD_WAIT;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    state_n = IDLE;
                    if (bus.RX_ERR) begin
                        err_n = 1'b1;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_data_n = bus.RX_P_DATA;
                    end
                end
            end
            RD_WAIT: begin
                // Bytes arriving while a read is outstanding are dropped and flagged.
                err_n = bus.RX_D_VLD;
                cnt_n = cnt_q + 1'b1;
                if (bus.RF_RdData_VLD) begin
                    tx_data_n = bus.RF_RdData;
                    state_n   = TX_PUSH;
                end else if (cnt_q == CNT_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            TX_PUSH: begin
                err_n = bus.RX_D_VLD;
                if (!bus.FIFO_FULL) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.RF_Address = addr_q;
    assign bus.RF_WrEn    = wr_en_q;
    assign bus.RF_RdEn    = rd_en_q;
    assign bus.RF_WrData  = wr_data_q;
    assign bus.TX_P_DATA  = tx_data_q;
    assign bus.TX_D_VLD   = (state_q == TX_PUSH) && !bus.FIFO_FULL;
    assign bus.Busy       = (state_q != IDLE);
    assign bus.CMD_ERR    = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame-level stimulus with expected strobe times
// derived from the frame rules, checked by an output monitor.
module tb_uart_cmd_ctrl;

    localparam int RD_TIMEOUT = 15;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] dbg_state;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    // Expected events: {cycle[31:0], 4'h0, addr[3:0], data[7:0]}
    logic [47:0] exp_wr_q[$];
    logic [47:0] exp_rd_q[$];
    logic [47:0] exp_tx_q[$];
    logic [47:0] exp_err_q[$];

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [47:0] ev(input int c, input logic [3:0] a, input logic [7:0] d);
        return {c[31:0], 4'h0, a, d};
    endfunction

    // Output monitor: every strobe must match the head of its expected queue.
    always @(negedge CLK) begin
        logic [47:0] e;
        if (bus.RF_WrEn === 1'b1 || bus.RF_RdEn === 1'b1)
            check("wr_rd_exclusive", 32'(bus.RF_WrEn & bus.RF_RdEn), 0);
        if (bus.RF_WrEn === 1'b1) begin
            if (exp_wr_q.size() == 0) check("wr_unexpected", 32'(bus.RF_WrEn), 0);
            else begin
                e = exp_wr_q.pop_front();
                check("wr_cycle", cyc, e[47:16]);
                check("wr_addr", 32'(bus.RF_Address), 32'(e[11:8]));
                check("wr_data", 32'(bus.RF_WrData), 32'(e[7:0]));
            end
        end
        if (bus.RF_RdEn === 1'b1) begin
            if (exp_rd_q.size() == 0) check("rd_unexpected", 32'(bus.RF_RdEn), 0);
            else begin
                e = exp_rd_q.pop_front();
                check("rd_cycle", cyc, e[47:16]);
                check("rd_addr", 32'(bus.RF_Address), 32'(e[11:8]));
            end
        end
        if (bus.TX_D_VLD === 1'b1) begin
            if (exp_tx_q.size() == 0) check("tx_unexpected", 32'(bus.TX_D_VLD), 0);
            else begin
                e = exp_tx_q.pop_front();
                check("tx_cycle", cyc, e[47:16]);
                check("tx_data", 32'(bus.TX_P_DATA), 32'(e[7:0]));
            end
        end
        if (bus.CMD_ERR === 1'b1) begin
            if (exp_err_q.size() == 0) check("err_unexpected", 32'(bus.CMD_ERR), 0);
            else begin
                e = exp_err_q.pop_front();
                check("err_cycle", cyc, e[47:16]);
            end
        end
    end

    // All driving happens 1 time unit after a rising edge ("slot").
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic err, output int c);
        c = cyc;
        bus.RX_D_VLD  = 1'b1;
        bus.RX_P_DATA = b;
        bus.RX_ERR    = err;
        @(posedge CLK); #1;
        bus.RX_D_VLD  = 1'b0;
        bus.RX_ERR    = 1'b0;
        bus.RX_P_DATA = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(bus.RF_Address), 0);
        check({tag, "_wren"},  32'(bus.RF_WrEn), 0);
        check({tag, "_rden"},  32'(bus.RF_RdEn), 0);
        check({tag, "_wdata"}, 32'(bus.RF_WrData), 0);
        check({tag, "_txdat"}, 32'(bus.TX_P_DATA), 0);
        check({tag, "_txvld"}, 32'(bus.TX_D_VLD), 0);
        check({tag, "_busy"},  32'(bus.Busy), 0);
        check({tag, "_err"},   32'(bus.CMD_ERR), 0);
    endtask

    // mode: 0 ok, 1 address out of range, 2 RX_ERR on address, 3 RX_ERR on data
    task automatic write_frame(input logic [3:0] a, input logic [7:0] d, input int mode);
        int c;
        logic [3:0] hi;
        drive_byte(8'hAA, 1'b0, c);
        check("wr_busy_open", 32'(bus.Busy), 1);
        idle($urandom_range(0, 2));
        if (mode == 1) begin
            hi = 4'($urandom_range(1, 15));
            drive_byte({hi, a}, 1'b0, c);
            exp_err_q.push_back(ev(c + 1, 4'h0, 8'h00));
        end else if (mode == 2) begin
            drive_byte({4'h0, a}, 1'b1, c);
            exp_err_q.push_back(ev(c + 1, 4'h0, 8'h00));
        end else begin
            drive_byte({4'h0, a}, 1'b0, c);
            idle($urandom_range(0, 2));
            if (mode == 3) begin
                drive_byte(d, 1'b1, c);
                exp_err_q.push_back(ev(c + 1, 4'h0, 8'h00));
            end else begin
                drive_byte(d, 1'b0, c);
                exp_wr_q.push_back(ev(c + 1, a, d));
            end
        end
        check("wr_busy_done", 32'(bus.Busy), 0);
    endtask

    // d: cycles after RF_RdEn until RF_RdData_VLD (>= RD_TIMEOUT means never);
    // f: cycles FIFO_FULL is held; stray: wait-cycle index of an injected byte (-1 none)
    task automatic read_frame(input logic [3:0] a, input logic [7:0] rdat, input int d,
                              input int f, input int stray, input int mode);
        int c;
        int e;
        int last;
        logic [3:0] hi;
        drive_byte(8'hBB, 1'b0, c);
        idle($urandom_range(0, 2));
        if (mode == 1) begin
            hi = 4'($urandom_range(1, 15));
            drive_byte({hi, a}, 1'b0, c);
            exp_err_q.push_back(ev(c + 1, 4'h0, 8'h00));
            return;
        end
        if (mode == 2) begin
            drive_byte({4'h0, a}, 1'b1, c);
            exp_err_q.push_back(ev(c + 1, 4'h0, 8'h00));
            return;
        end
        drive_byte({4'h0, a}, 1'b0, c);
        e = c + 1;
        exp_rd_q.push_back(ev(e, a, 8'h00));
        last = (d < RD_TIMEOUT) ? d : RD_TIMEOUT - 1;
        for (int k = 0; k <= last; k++) begin
            if (k == stray) begin
                bus.RX_D_VLD  = 1'b1;
                bus.RX_P_DATA = 8'($urandom);
                bus.RX_ERR    = 1'($urandom_range(0, 1));
                exp_err_q.push_back(ev(e + k + 1, 4'h0, 8'h00));
            end
            if (k == d) begin
                bus.RF_RdData_VLD = 1'b1;
                bus.RF_RdData     = rdat;
            end
            @(posedge CLK); #1;
            bus.RX_D_VLD      = 1'b0;
            bus.RX_ERR        = 1'b0;
            bus.RF_RdData_VLD = 1'b0;
            bus.RF_RdData     = 8'($urandom);
        end
        if (d >= RD_TIMEOUT) begin
            exp_err_q.push_back(ev(e + RD_TIMEOUT, 4'h0, 8'h00));
            // Late data after the abort must be ignored.
            bus.RF_RdData_VLD = 1'b1;
            @(posedge CLK); #1;
            bus.RF_RdData_VLD = 1'b0;
        end else begin
            for (int j = 0; j < f; j++) begin
                bus.FIFO_FULL = 1'b1;
                @(negedge CLK);
                check("bp_txvld", 32'(bus.TX_D_VLD), 0);
                check("bp_txdata", 32'(bus.TX_P_DATA), 32'(rdat));
                check("bp_busy", 32'(bus.Busy), 1);
                @(posedge CLK); #1;
            end
            bus.FIFO_FULL = 1'b0;
            exp_tx_q.push_back(ev(e + d + 1 + f, 4'h0, rdat));
            @(posedge CLK); #1;
        end
        check("rd_busy_done", 32'(bus.Busy), 0);
    endtask

    initial begin
        int c;
        int r;
        int d;
        int stray;
        logic [7:0] b;

        RST                = 1'b1;
        bus.RX_P_DATA      = '0;
        bus.RX_D_VLD       = 1'b0;
        bus.RX_ERR         = 1'b0;
        bus.RF_RdData      = '0;
        bus.RF_RdData_VLD  = 1'b0;
        bus.FIFO_FULL      = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b0;
        idle(1);

        // Directed frames from the test plan
        write_frame(4'h3, 8'h5C, 0);
        read_frame(4'h7, 8'h9E, 2, 0, -1, 0);
        read_frame(4'h7, 8'h9E, 2, 10, -1, 0);
        drive_byte(8'hAA, 1'b0, c);
        drive_byte(8'h13, 1'b0, c);
        exp_err_q.push_back(ev(c + 1, 4'h0, 8'h00));
        write_frame(4'h2, 8'h00, 3);
        drive_byte(8'h55, 1'b0, c);
        drive_byte(8'hAA, 1'b1, c);
        drive_byte(8'h03, 1'b0, c);
        check("idle_stray_busy", 32'(bus.Busy), 0);
        read_frame(4'h1, 8'h00, RD_TIMEOUT, 0, -1, 0);
        write_frame(4'h1, 8'h22, 0);
        read_frame(4'h5, 8'hC3, RD_TIMEOUT - 1, 0, 3, 0);

        // Back-to-back frames with no gap
        write_frame(4'hF, 8'hFF, 0);
        write_frame(4'h0, 8'h01, 0);

        // Reset in the middle of a write frame
        drive_byte(8'hAA, 1'b0, c);
        drive_byte(8'h04, 1'b0, c);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_reset_outputs("midreset");
        RST = 1'b0;
        drive_byte(8'h22, 1'b0, c);
        idle(3);

        // Randomized frame mix
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                write_frame(4'($urandom), 8'($urandom),
                            ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
            end else if (r <= 7) begin
                d = ($urandom_range(0, 5) == 0) ? RD_TIMEOUT : $urandom_range(0, RD_TIMEOUT - 1);
                stray = -1;
                if ($urandom_range(0, 2) == 0)
                    stray = $urandom_range(0, (d < RD_TIMEOUT) ? d : RD_TIMEOUT - 2);
                read_frame(4'($urandom), 8'($urandom), d,
                           ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, stray,
                           ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
            end else begin
                b = 8'($urandom);
                if (b == 8'hAA || b == 8'hBB) b = 8'h55;
                drive_byte(b, 1'($urandom_range(0, 1)), c);
            end
            idle($urandom_range(0, 2));
        end

        idle(5);
        check("exp_wr_left", exp_wr_q.size(), 0);
        check("exp_rd_left", exp_rd_q.size(), 0);
        check("exp_tx_left", exp_tx_q.size(), 0);
        check("exp_err_left", exp_err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
